// File: rtl/uart_tx_fifo_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_feeder
// Buffers transmit words coming from the USB bulk-OUT path and hands them to
// the UART transmitter one at a time. TX_BUSY (transmitter busy OR CTS high)
// throttles dispatch. After each send pulse the block gives the UART up to
// BUSY_WAIT cycles to raise TX_BUSY before it assumes the word was taken.
//
// Ports
//   i_clk           system clock
//   i_rst           synchronous active-high reset, highest priority
//   i_wr_data       word to enqueue
//   i_wr_en         enqueue strobe
//   i_flush         synchronous FIFO clear (does not disturb an in-flight send)
//   o_full          FIFO holds 2**DEPTH_LOG2 words
//   o_empty         FIFO holds no words
//   o_level         current word count
//   o_overflow      one-cycle pulse after a write was dropped on a full FIFO
//   o_tx_data       word presented to the UART, held until the next pop
//   o_tx_data_val   one-cycle send pulse
//   i_tx_busy       UART busy / CTS deasserted
// ---------------------------------------------------------------------------
module uart_tx_fifo_feeder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 16,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_wr_en,
    input  logic                  i_flush,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic [DATA_W-1:0]     o_tx_data,
    output logic                  o_tx_data_val,
    input  logic                  i_tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [3:0]            CNT_LAST   = 4'(BUSY_WAIT - 1);
    localparam logic [3:0]            CNT_ONE    = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic [DATA_W-1:0]     r_tx_data;
    logic                  r_tx_data_val;
    logic [3:0]            r_busy_cnt;
    state_t                r_state;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == FULL_LEVEL);
    assign w_empty = (r_level == '0);

    // A write is accepted only when there is room before this edge; a pop in
    // the same cycle does not make room for it. FLUSH discards both.
    assign w_push = i_wr_en & ~w_full & ~i_flush;
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & ~i_tx_busy & ~i_flush;

    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_level       = r_level;
    assign o_overflow    = r_overflow;
    assign o_tx_data     = r_tx_data;
    assign o_tx_data_val = r_tx_data_val;

    // Storage array; no reset needed since reads are qualified by r_level.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer, level and overflow bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            // Writes during a flush are discarded silently.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_wr_en & w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Dispatch FSM: pop and pulse, wait for busy (or time out), wait for idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= '0;
            r_tx_data_val <= 1'b0;
            r_busy_cnt    <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data     <= r_mem[r_rd_ptr];
                        r_tx_data_val <= 1'b1;
                        r_busy_cnt    <= 4'd0;
                        r_state       <= ST_WAIT_BUSY;
                    end else begin
                        r_tx_data_val <= 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    r_tx_data_val <= 1'b0;
                    if (i_tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_busy_cnt == CNT_LAST) begin
                        // UART never reported busy; the word counts as taken.
                        r_state <= ST_IDLE;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    r_tx_data_val <= 1'b0;
                    if (!i_tx_busy) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    r_tx_data_val <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo_feeder
// Directed scenarios followed by a randomized phase. A queue-based reference
// model predicts every output each cycle; directed steps add fixed checks.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_feeder;

    localparam int DL = 6;
    localparam int DW = 16;
    localparam int BW = 4;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wr_data = 16'h0000;
    logic          wr_en = 1'b0;
    logic          flush = 1'b0;
    logic          tx_busy = 1'b0;
    logic          full, empty, overflow, tx_val;
    logic [DL:0]   level;
    logic [DW-1:0] tx_data;

    always #5 clk = ~clk;

    uart_tx_fifo_feeder #(.DEPTH_LOG2(DL), .DATA_W(DW), .BUSY_WAIT(BW)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .i_flush(flush), .o_full(full), .o_empty(empty), .o_level(level),
        .o_overflow(overflow), .o_tx_data(tx_data), .o_tx_data_val(tx_val),
        .i_tx_busy(tx_busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    logic [DW-1:0] m_q[$];
    int            m_hs_elapsed = -1;   // -1: no handshake in progress
    bit            m_seen_busy = 1'b0;
    logic [DW-1:0] m_txd = 16'h0000;
    bit            m_val = 1'b0;
    bit            m_ovf = 1'b0;

    logic [DW-1:0] sent[$];
    bit            uart_on = 1'b0;
    int            u_t = -1;
    int            ovf_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Predict the effect of one clock edge from the inputs presented to it.
    task automatic model_edge();
        bit was_full, do_pop;
        if (rst) begin
            m_q.delete();
            m_hs_elapsed = -1; m_seen_busy = 1'b0;
            m_txd = 16'h0000; m_val = 1'b0; m_ovf = 1'b0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        do_pop   = (m_hs_elapsed < 0) && (m_q.size() > 0) && !tx_busy && !flush;
        m_ovf    = wr_en && was_full && !flush;
        m_val    = 1'b0;
        if (m_hs_elapsed >= 0) begin
            if (m_seen_busy) begin
                if (!tx_busy) m_hs_elapsed = -1;
            end else if (tx_busy) begin
                m_seen_busy = 1'b1;
            end else if (m_hs_elapsed == BW - 1) begin
                m_hs_elapsed = -1;
            end else begin
                m_hs_elapsed++;
            end
        end
        if (flush) begin
            m_q.delete();
        end else begin
            if (do_pop) begin
                m_txd = m_q.pop_front();
                m_val = 1'b1;
                m_hs_elapsed = 0;
                m_seen_busy = 1'b0;
            end
            if (wr_en && !was_full) m_q.push_back(wr_data);
        end
    endtask

    task automatic check_all();
        chk("level",    32'(level),    32'(m_q.size()));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tx_val",   32'(tx_val),   32'(m_val));
        chk("tx_data",  32'(tx_data),  32'(m_txd));
        if (tx_val === 1'b1) sent.push_back(tx_data);
    endtask

    // One clock: model, edge, sample 1ns later, then let the UART model react.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        if (uart_on) begin
            if (tx_val === 1'b1) u_t = 0;
            else if (u_t >= 0) u_t++;
            if (u_t >= 11) u_t = -1;
            tx_busy = (u_t >= 1 && u_t <= 10);
        end
    endtask

    task automatic drain(input int budget, input int want);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (sent.size() == want && level == '0) done = 1'b1;
        end
        chk("drain_within_budget", 32'(done), 32'd1);
        for (int i = 0; i < 20; i++) step();
    endtask

    initial begin
        int bad;
        // reset state
        rst = 1'b1; step(); step();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_txd",   32'(tx_data), 32'd0);
        rst = 1'b0;

        // single word, latency one edge after the write
        wr_en = 1'b1; wr_data = 16'h00A5; step();
        chk("t1_level_after_write", 32'(level), 32'd1);
        chk("t1_no_pulse_yet", 32'(tx_val), 32'd0);
        wr_en = 1'b0; step();
        chk("t1_pulse", 32'(tx_val), 32'd1);
        chk("t1_data", 32'(tx_data), 32'h00A5);
        chk("t1_level_after_pop", 32'(level), 32'd0);
        step();
        chk("t1_pulse_one_cycle", 32'(tx_val), 32'd0);
        for (int i = 0; i < BW + 3; i++) step();

        // five words through a UART that goes busy for 10 cycles per word
        sent.delete(); uart_on = 1'b1; u_t = -1; tx_busy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 16'(i); step();
        end
        wr_en = 1'b0;
        drain(300, 5);
        chk("t2_count", 32'(sent.size()), 32'd5);
        bad = 0;
        foreach (sent[k]) if (sent[k] !== 16'(k + 1)) bad++;
        chk("t2_order", 32'(bad), 32'd0);

        // CTS stall, overfill, then full-and-popping with a write
        uart_on = 1'b0; tx_busy = 1'b1; ovf_seen = 0;
        for (int i = 1; i <= 66; i++) begin
            wr_en = 1'b1; wr_data = 16'(i); step();
            if (overflow === 1'b1) ovf_seen++;
            if (i == 64) begin
                chk("t3_full_at_64", 32'(full), 32'd1);
                chk("t3_level_64", 32'(level), 32'd64);
            end
        end
        chk("t3_overflow_pulses", 32'(ovf_seen), 32'd2);
        sent.delete(); uart_on = 1'b1; u_t = -1; tx_busy = 1'b0;
        wr_data = 16'd67; step();
        chk("t4_drop_overflow", 32'(overflow), 32'd1);
        chk("t4_level_63", 32'(level), 32'd63);
        wr_en = 1'b0;
        drain(1500, 64);
        chk("t3_count", 32'(sent.size()), 32'd64);
        bad = 0;
        foreach (sent[k]) if (sent[k] !== 16'(k + 1)) bad++;
        chk("t3_order", 32'(bad), 32'd0);

        // flush while a word is in WAIT_DONE
        uart_on = 1'b0; tx_busy = 1'b0;
        wr_en = 1'b1; wr_data = 16'h0100; step();
        wr_en = 1'b0; step();
        chk("t5_inflight_pulse", 32'(tx_val), 32'd1);
        tx_busy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; wr_data = 16'(16'h0100 + i); step();
        end
        chk("t5_level_10", 32'(level), 32'd10);
        flush = 1'b1; wr_data = 16'h0BAD; step();
        chk("t5_flush_level", 32'(level), 32'd0);
        chk("t5_flush_no_ovf", 32'(overflow), 32'd0);
        flush = 1'b0; wr_en = 1'b0; sent.delete();
        for (int i = 0; i < 5; i++) step();
        tx_busy = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("t5_no_more_pulses", 32'(sent.size()), 32'd0);

        // reset during WAIT_BUSY with five words queued
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'(16'h0200 + i); step();
        end
        tx_busy = 1'b0; wr_data = 16'h0205; step();
        chk("t6_pulse", 32'(tx_val), 32'd1);
        chk("t6_level_5", 32'(level), 32'd5);
        wr_en = 1'b0; rst = 1'b1; step();
        chk("t6_val", 32'(tx_val), 32'd0);
        chk("t6_txd", 32'(tx_data), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        rst = 1'b0; sent.delete();
        for (int i = 0; i < 10; i++) step();
        chk("t6_no_pulse", 32'(sent.size()), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            rst     = (r < 4);
            flush   = (r >= 4 && r < 20);
            wr_en   = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 45 : 80));
            wr_data = 16'($urandom);
            tx_busy = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 25 : 70));
            step();
        end
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
